blake2_blk_sched: RTL and testbench
===================================

Name: blake2_blk_sched

Overview:
- Sequencer in front of the blake2 compression core.
- Accepts the message length plus a byte stream from the host, and cuts it into BB-byte blocks.
- Drives the core's byte-load interface with block index, first/last flags and byte count, and zero-pads the final block.
- Waits for each compression, then collects the NN-byte digest into a result stream.

Parameters:
- BB, 128, block size in bytes (128 blake2b, 64 blake2s).
- LL_W, 64, width of message byte-length counter.
- IDX_W, $clog2(BB), width of byte index within block.

Ports:
- clk  in  1  clock, single domain.
- nreset  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse that begins a hash; sampled only in S_IDLE.
- ll_i  in  LL_W  total message bytes; captured on start_i.
- nn_i  in  8  digest bytes, 1..BB/2; captured on start_i.
- kk_i  in  8  key bytes, 0..BB/2; captured on start_i.
- s_valid_i  in  1  host byte valid.
- s_data_i  in  8  host byte (key bytes first, then message).
- s_ready_o  out  1  host byte accept.
- core_data_v_o  out  1  byte valid to core.
- core_data_idx_o  out  IDX_W  byte position in block.
- core_data_o  out  8  byte to core.
- core_block_first_o  out  1  current block is block 0.
- core_block_last_o  out  1  current block is final.
- core_ll_o  out  2*LL_W  byte count for core t.
- core_kk_o  out  8  latched key length.
- core_nn_o  out  8  latched digest length.
- core_finished_i  in  1  core pulse: compression of loaded block done.
- core_h_v_i  in  1  digest byte valid from core.
- core_h_i  in  8  digest byte from core, LSB-first.
- res_v_o  out  1  digest byte valid.
- res_o  out  8  digest byte.
- res_last_o  out  1  final digest byte (nn-th).
- busy_o  out  1  high outside S_IDLE.

Behaviour:
- Reset (async, nreset low): state S_IDLE; all outputs 0; counters 0.
  - Reset mid-operation abandons the hash; the core is not notified.
- States:
  - S_IDLE -> S_LOAD on start_i.
  - S_LOAD: s_ready_o=1. Each accepted byte (s_valid_i&s_ready_o) is forwarded the same cycle: core_data_v_o=1, core_data_o=s_data_i, core_data_idx_o=byte_idx.
    - byte_idx increments, wrapping at BB-1.
    - Bytes-remaining counter decrements.
    - When remaining reaches 0 mid-block -> S_PAD. If byte_idx==BB-1 -> S_WAIT.
  - S_PAD: s_ready_o=0. Emits 0x00 each cycle at idx byte_idx..BB-1, then -> S_WAIT.
  - S_WAIT: no core_data_v_o. On core_finished_i: if the block was last -> S_RES, else -> S_LOAD with block counter +1.
  - S_RES: forward core_h_v_i/core_h_i to res_v_o/res_o combinationally.
    - Count bytes; res_last_o with the nn-th byte; further core bytes dropped. Then -> S_IDLE.
- Bubbles: no core_data_v_o in cycles with s_valid_i=0; the core tolerates gaps.
- core_block_first_o=1 while block counter==0.
- core_block_last_o=1 while loading the block containing the final byte, or a block entered with remaining==0.
  - Held constant from the block's idx 0 through S_WAIT.
- Byte accounting:
  - core_ll_o = cumulative bytes counted so far, including the current block, excluding padding.
  - Zero-extended from LL_W. Valid whenever core_data_v_o.
- Boundaries:
  - ll_i=0, kk=0: enter S_PAD directly from idx 0; one all-zero block; first=last=1; ll=0.
  - ll_i a multiple of BB: no extra padding block; last asserted on the final full block.
- start_i outside S_IDLE ignored; nn_i=0 treated as 1.

Optional Feature:
- BLAKE2_KEY_EN defined:
  - If kk_i!=0, S_LOAD first accepts kk bytes as key, then zero-pads to BB as block 0; message starts at block 1.
  - The key block counts BB bytes toward core_ll_o.
  - If ll_i==0, the key block is last.
- Undefined: kk_i is ignored and core_kk_o=0; the first host byte is message byte 0.

Test Plan:
- ll=0, nn=64: one block, idx 0..127 all 0x00, first=last=1, core_ll=0; 64 res bytes, res_last on byte 64.
- ll=3 "abc", nn=32: bytes 61,62,63 at idx 0..2, then 125 zero bytes; first=last=1, core_ll=3; 32 result bytes.
- ll=128: a single block with no padding, last=1, core_ll=128; exactly one core_finished_i wait.
- ll=129: block0 first=1 last=0, ll=128; after finished, block1 first=0 last=1, 1 data byte + 127 pad, ll=129.
- ll=200 with s_valid_i toggling every other cycle, then nreset pulse mid-block 1: idx gap-free per accepted byte; reset -> S_IDLE, busy_o=0, s_ready_o=0 immediately.
- BLAKE2_KEY_EN, kk=32, ll=3: block0 = 32 key bytes + 96 zeros, last=0, ll=128; block1 = 3 msg bytes, last=1, ll=131.

Source files
------------

// File: rtl/blake2_blk_sched.sv
// blake2_blk_sched: block sequencer in front of the blake2 compression core.
// Cuts a host byte stream into BB-byte blocks, zero-pads the final block,
// waits for each compression and forwards the NN-byte digest.
// Optional keyed mode: define BLAKE2_KEY_EN to prepend a zero-padded key block.
module blake2_blk_sched #(
   parameter int BB    = 128,
   parameter int LL_W  = 64,
   parameter int IDX_W = $clog2(BB)
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start_i,
   input  logic [LL_W-1:0]   ll_i,
   input  logic [7:0]        nn_i,
   input  logic [7:0]        kk_i,
   input  logic              s_valid_i,
   input  logic [7:0]        s_data_i,
   output logic              s_ready_o,
   output logic              core_data_v_o,
   output logic [IDX_W-1:0]  core_data_idx_o,
   output logic [7:0]        core_data_o,
   output logic              core_block_first_o,
   output logic              core_block_last_o,
   output logic [2*LL_W-1:0] core_ll_o,
   output logic [7:0]        core_kk_o,
   output logic [7:0]        core_nn_o,
   input  logic              core_finished_i,
   input  logic              core_h_v_i,
   input  logic [7:0]        core_h_i,
   output logic              res_v_o,
   output logic [7:0]        res_o,
   output logic              res_last_o,
   output logic              busy_o
);

`ifdef BLAKE2_KEY_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif

   localparam logic [LL_W-1:0]  BB_LL   = LL_W'(BB);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BB - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PAD,
      S_WAIT,
      S_RES
   } state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;          // byte position within the block
   logic [LL_W-1:0]   rem_q, rem_d;          // message bytes still to accept
   logic [7:0]        key_rem_q, key_rem_d;  // key bytes still to accept
   logic              key_ph_q, key_ph_d;    // current block is the key block
   logic [LL_W-1:0]   blk_cnt_q, blk_cnt_d;
   logic [LL_W-1:0]   blk_ll_q, blk_ll_d;    // byte count through current block
   logic              last_q, last_d;
   logic [7:0]        nn_q, nn_d;
   logic [7:0]        kk_q, kk_d;
   logic [7:0]        res_cnt_q, res_cnt_d;

   logic [7:0]        kk_eff;
   logic              load_open;
   logic              src_last;

   // Key length only matters in keyed builds.
   assign kk_eff    = KEY_EN ? kk_i : 8'd0;
   // A message block entered with nothing left to load goes straight to padding.
   assign load_open = key_ph_q | (rem_q != '0);
   // The byte accepted this cycle is the final one of its source (key or message).
   assign src_last  = key_ph_q ? (key_rem_q == 8'd1) : (rem_q == LL_W'(1));

   // Static status outputs derived from the registered block context.
   assign busy_o             = (state_q != S_IDLE);
   assign core_block_first_o = busy_o & (blk_cnt_q == '0);
   assign core_block_last_o  = busy_o & last_q;
   assign core_data_idx_o    = idx_q;
   assign core_ll_o          = {{LL_W{1'b0}}, blk_ll_q};
   assign core_kk_o          = kk_q;
   assign core_nn_o          = nn_q;

   // State register and counters.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         rem_q     <= '0;
         key_rem_q <= '0;
         key_ph_q  <= 1'b0;
         blk_cnt_q <= '0;
         blk_ll_q  <= '0;
         last_q    <= 1'b0;
         nn_q      <= '0;
         kk_q      <= '0;
         res_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rem_q     <= rem_d;
         key_rem_q <= key_rem_d;
         key_ph_q  <= key_ph_d;
         blk_cnt_q <= blk_cnt_d;
         blk_ll_q  <= blk_ll_d;
         last_q    <= last_d;
         nn_q      <= nn_d;
         kk_q      <= kk_d;
         res_cnt_q <= res_cnt_d;
      end
   end

   // Next-state logic and per-cycle core / host / result handshakes.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d       = state_q;
      idx_d         = idx_q;
      rem_d         = rem_q;
      key_rem_d     = key_rem_q;
      key_ph_d      = key_ph_q;
      blk_cnt_d     = blk_cnt_q;
      blk_ll_d      = blk_ll_q;
      last_d        = last_q;
      nn_d          = nn_q;
      kk_d          = kk_q;
      res_cnt_d     = res_cnt_q;
      s_ready_o     = 1'b0;
      core_data_v_o = 1'b0;
      core_data_o   = 8'd0;
      res_v_o       = 1'b0;
      res_o         = 8'd0;
      res_last_o    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_LOAD;
               idx_d     = '0;
               rem_d     = ll_i;
               blk_cnt_d = '0;
               res_cnt_d = '0;
               nn_d      = (nn_i == 8'd0) ? 8'd1 : nn_i;
               kk_d      = kk_eff;
               key_ph_d  = (kk_eff != 8'd0);
               key_rem_d = kk_eff;
               if (kk_eff != 8'd0) begin
                  // Key block always counts a full block and is last only for empty messages.
                  last_d   = (ll_i == '0);
                  blk_ll_d = BB_LL;
               end else begin
                  last_d   = (ll_i <= BB_LL);
                  blk_ll_d = (ll_i < BB_LL) ? ll_i : BB_LL;
               end
            end
         end

         S_LOAD: begin
            s_ready_o = load_open;
            if (!load_open) begin
               state_d = S_PAD;
            end else if (s_valid_i) begin
               core_data_v_o = 1'b1;
               core_data_o   = s_data_i;
               idx_d         = idx_q + IDX_W'(1);
               if (key_ph_q) key_rem_d = key_rem_q - 8'd1;
               else          rem_d     = rem_q - LL_W'(1);
               if (idx_q == IDX_MAX) state_d = S_WAIT;
               else if (src_last)    state_d = S_PAD;
            end
         end

         S_PAD: begin
            core_data_v_o = 1'b1;
            idx_d         = idx_q + IDX_W'(1);
            if (idx_q == IDX_MAX) state_d = S_WAIT;
         end

         S_WAIT: begin
            if (core_finished_i) begin
               if (last_q) begin
                  state_d   = S_RES;
                  res_cnt_d = '0;
               end else begin
                  state_d   = S_LOAD;
                  blk_cnt_d = blk_cnt_q + LL_W'(1);
                  key_ph_d  = 1'b0;
                  last_d    = (rem_q <= BB_LL);
                  blk_ll_d  = blk_ll_q + ((rem_q < BB_LL) ? rem_q : BB_LL);
               end
            end
         end

         S_RES: begin
            if (core_h_v_i) begin
               res_v_o   = 1'b1;
               res_o     = core_h_i;
               res_cnt_d = res_cnt_q + 8'd1;
               if (res_cnt_q == nn_q - 8'd1) begin
                  res_last_o = 1'b1;
                  state_d    = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_blake2_blk_sched.sv
// Self-checking bench for blake2_blk_sched: randomized host/core timing against
// a block-level reference model (expected write list and digest stream).
// Honours BLAKE2_KEY_EN the same way the design does.
`timescale 1ns/1ps
module tb_blake2_blk_sched;

   localparam int BB    = 128;
   localparam int LL_W  = 64;
   localparam int IDX_W = $clog2(BB);

`ifdef BLAKE2_KEY_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif

   logic              clk;
   logic              nreset;
   logic              start_i;
   logic [LL_W-1:0]   ll_i;
   logic [7:0]        nn_i;
   logic [7:0]        kk_i;
   logic              s_valid_i;
   logic [7:0]        s_data_i;
   logic              s_ready_o;
   logic              core_data_v_o;
   logic [IDX_W-1:0]  core_data_idx_o;
   logic [7:0]        core_data_o;
   logic              core_block_first_o;
   logic              core_block_last_o;
   logic [2*LL_W-1:0] core_ll_o;
   logic [7:0]        core_kk_o;
   logic [7:0]        core_nn_o;
   logic              core_finished_i;
   logic              core_h_v_i;
   logic [7:0]        core_h_i;
   logic              res_v_o;
   logic [7:0]        res_o;
   logic              res_last_o;
   logic              busy_o;

   blake2_blk_sched #(.BB(BB), .LL_W(LL_W), .IDX_W(IDX_W)) dut (
      .clk                (clk),
      .nreset             (nreset),
      .start_i            (start_i),
      .ll_i               (ll_i),
      .nn_i               (nn_i),
      .kk_i               (kk_i),
      .s_valid_i          (s_valid_i),
      .s_data_i           (s_data_i),
      .s_ready_o          (s_ready_o),
      .core_data_v_o      (core_data_v_o),
      .core_data_idx_o    (core_data_idx_o),
      .core_data_o        (core_data_o),
      .core_block_first_o (core_block_first_o),
      .core_block_last_o  (core_block_last_o),
      .core_ll_o          (core_ll_o),
      .core_kk_o          (core_kk_o),
      .core_nn_o          (core_nn_o),
      .core_finished_i    (core_finished_i),
      .core_h_v_i         (core_h_v_i),
      .core_h_i           (core_h_i),
      .res_v_o            (res_v_o),
      .res_o              (res_o),
      .res_last_o         (res_last_o),
      .busy_o             (busy_o)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One expected byte write to the core.
   typedef struct {
      int     idx;
      int     data;
      bit     first;
      bit     last;
      longint ll;
   } wr_t;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One complete hash: build the expected block image, then run host and core
   // side with random timing, comparing every core write and every digest byte.
   task automatic run_hash(input int ll, input int nn, input int kk, input bit abc,
                           input bit alt, input int abort_at);
      wr_t        exp_q[$];
      logic [7:0] key_b[$];
      logic [7:0] msg_b[$];
      logic [7:0] host_q[$];
      logic [7:0] dig[$];
      wr_t        w;
      int nn_eff, kk_eff, base, nblk, nmb, cnt;
      int hp, acc, wp, blk_bytes, fin_wait, rp, dp, drain, cyc;
      bit in_res, done, waiting, aborted, timed_out;

      nn_eff = (nn == 0) ? 1 : nn;
      kk_eff = KEY_EN ? kk : 0;
      for (int i = 0; i < kk_eff; i++) key_b.push_back(8'($urandom));
      for (int i = 0; i < ll; i++)     msg_b.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
      host_q = {key_b, msg_b};

      base = 0;
      nblk = 0;
      if (kk_eff != 0) begin
         for (int i = 0; i < BB; i++) begin
            w.idx = i; w.data = (i < kk_eff) ? int'(key_b[i]) : 0;
            w.first = 1'b1; w.last = (ll == 0); w.ll = BB;
            exp_q.push_back(w);
         end
         base = BB;
         nblk = 1;
      end
      nmb = (ll == 0) ? ((nblk == 0) ? 1 : 0) : (ll + BB - 1) / BB;
      for (int b = 0; b < nmb; b++) begin
         cnt = ll - b * BB;
         if (cnt > BB) cnt = BB;
         for (int i = 0; i < BB; i++) begin
            w.idx = i; w.data = (i < cnt) ? int'(msg_b[b * BB + i]) : 0;
            w.first = (nblk + b == 0); w.last = (b == nmb - 1);
            w.ll = base + b * BB + cnt;
            exp_q.push_back(w);
         end
      end
      for (int i = 0; i < nn_eff + 8; i++) dig.push_back(8'($urandom));

      @(negedge clk);
      start_i = 1'b1; ll_i = LL_W'(ll); nn_i = 8'(nn); kk_i = 8'(kk); s_valid_i = 1'b0;
      @(negedge clk);
      start_i = 1'b0;
      check("busy_after_start", busy_o, 1);

      hp = 0; acc = 0; wp = 0; blk_bytes = 0; fin_wait = -1; rp = 0; dp = 0;
      drain = 0; cyc = 0; in_res = 0; done = 0; aborted = 0; timed_out = 0;
      while (!done) begin
         s_valid_i       = alt ? (cyc % 2 == 1) : ($urandom_range(0, 3) != 0);
         s_data_i        = (hp < host_q.size()) ? host_q[hp] : 8'($urandom);
         core_finished_i = (fin_wait == 0);
         core_h_v_i      = in_res && ($urandom_range(0, 2) != 0);
         core_h_i        = (dp < dig.size()) ? dig[dp] : 8'h00;
         start_i         = (cyc == 7);
         ll_i            = {$urandom, $urandom};
         nn_i            = 8'($urandom_range(1, 64));
         kk_i            = 8'($urandom_range(0, 64));
         #1;
         if (s_valid_i && s_ready_o) begin
            acc++;
            hp++;
         end
         waiting = (fin_wait >= 0);
         if (waiting) check("wait_no_write", core_data_v_o, 0);
         if (fin_wait == 0) begin
            fin_wait = -1;
            if (wp >= exp_q.size()) in_res = 1;
         end else if (fin_wait > 0) begin
            fin_wait--;
         end
         if (!waiting && core_data_v_o) begin
            if (wp < exp_q.size()) begin
               w = exp_q[wp];
               check($sformatf("wr_idx@%0d", wp),   core_data_idx_o, w.idx);
               check($sformatf("wr_data@%0d", wp),  core_data_o, w.data);
               check($sformatf("wr_first@%0d", wp), core_block_first_o, w.first);
               check($sformatf("wr_last@%0d", wp),  core_block_last_o, w.last);
               check($sformatf("wr_ll@%0d", wp),    core_ll_o, w.ll);
               if (wp == 0) begin
                  check("core_kk", core_kk_o, kk_eff);
                  check("core_nn", core_nn_o, nn_eff);
               end
            end
            wp++;
            blk_bytes++;
            if (blk_bytes == BB) begin
               blk_bytes = 0;
               fin_wait  = $urandom_range(1, 4);
            end
         end
         if (core_h_v_i) begin
            if (rp < nn_eff) begin
               check($sformatf("res_v@%0d", rp),    res_v_o, 1);
               check($sformatf("res_data@%0d", rp), res_o, dig[dp]);
               check($sformatf("res_last@%0d", rp), res_last_o, (rp == nn_eff - 1));
               rp++;
            end else begin
               check("res_drop", res_v_o, 0);
            end
            dp++;
         end else begin
            check("res_idle", res_v_o, 0);
         end
         if (rp == nn_eff) drain++;
         if (drain > 4) done = 1;
         if (abort_at > 0 && wp >= abort_at) begin
            done    = 1;
            aborted = 1;
         end
         cyc++;
         if (cyc > 20000) begin
            check("timeout_cycles", cyc, 20000);
            done      = 1;
            timed_out = 1;
         end
         @(negedge clk);
      end

      core_h_v_i = 1'b0; core_finished_i = 1'b0; start_i = 1'b0; s_valid_i = 1'b0;
      if (aborted) begin
         s_valid_i = 1'b1;
         nreset    = 1'b0;
         #1;
         check("rst_busy",   busy_o, 0);
         check("rst_ready",  s_ready_o, 0);
         check("rst_data_v", core_data_v_o, 0);
         check("rst_first",  core_block_first_o, 0);
         check("rst_ll",     core_ll_o, 0);
         @(negedge clk);
         nreset    = 1'b1;
         s_valid_i = 1'b0;
      end else if (!timed_out) begin
         check("end_writes",  wp, exp_q.size());
         check("end_accepts", acc, host_q.size());
         check("end_busy",    busy_o, 0);
         check("end_ready",   s_ready_o, 0);
      end
   endtask

   initial begin
      nreset = 1'b0; start_i = 1'b0; ll_i = '0; nn_i = '0; kk_i = '0;
      s_valid_i = 1'b0; s_data_i = '0; core_finished_i = 1'b0;
      core_h_v_i = 1'b0; core_h_i = '0;
      #2;
      check("reset_busy",   busy_o, 0);
      check("reset_ready",  s_ready_o, 0);
      check("reset_data_v", core_data_v_o, 0);
      check("reset_first",  core_block_first_o, 0);
      check("reset_last",   core_block_last_o, 0);
      check("reset_ll",     core_ll_o, 0);
      check("reset_res_v",  res_v_o, 0);
      check("reset_kk_nn",  {core_kk_o, core_nn_o}, 0);
      #20;
      @(negedge clk);
      nreset = 1'b1;

      run_hash(0,   64, 0,  0, 0, 0);
      run_hash(3,   32, 0,  1, 0, 0);
      run_hash(128, 32, 0,  0, 0, 0);
      run_hash(129, 64, 0,  0, 0, 0);
      run_hash(200, 16, 0,  0, 1, BB + 50);
      run_hash(256, 0,  0,  0, 0, 0);
      run_hash(3,   32, 32, 1, 0, 0);
      run_hash(0,   20, 64, 0, 0, 0);
      run_hash(130, 8,  1,  0, 1, 0);
      for (int n = 0; n < 4; n++)
         run_hash($urandom_range(0, 400), $urandom_range(1, 64), $urandom_range(0, 64),
                  0, 1'($urandom_range(0, 1)), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
